// File: rtl/sprite_fetch_pkg.sv
// Shared constants, fetch state encoding and sprite-row packing helper for sprite_fetch.
// Optional macro SPRITE_FETCH_CLIP_EN is consumed by sprite_fetch.sv.
package sprite_fetch_pkg;

  localparam int ADDR_W   = 12;
  localparam int MAX_ROWS = 15;
  localparam int SCREEN_W = 64;
  localparam int SCREEN_H = 32;
  localparam int SPRITE_W = 8 * MAX_ROWS;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAW,
    ST_DONE
  } fetch_state_t;

  // Row k lands in the k-th byte from the top; the bus is cleared at start so OR is safe.
  function automatic logic [SPRITE_W-1:0] place_row(input logic [SPRITE_W-1:0] bus,
                                                    input logic [3:0]          k,
                                                    input logic [7:0]          b);
    logic [SPRITE_W-1:0] top;
    top = {b, {(SPRITE_W-8){1'b0}}};
    return bus | (top >> {k, 3'b000});
  endfunction

endpackage

// File: rtl/sprite_fetch_if.sv
// Sprite memory read port: request/address held until the memory answers with valid/data.
interface sprite_fetch_if;
  import sprite_fetch_pkg::*;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_valid;
  logic [7:0]        mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_valid, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_valid, output mem_rdata);
endinterface

// File: rtl/sprite_fetch.sv
// DXYN sprite fetcher: reads N bytes at I, packs them MSbyte-first, wraps X/Y, strobes draw.
// Define SPRITE_FETCH_CLIP_EN to clip height (and fetches) at the bottom screen edge.
module sprite_fetch
  import sprite_fetch_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [3:0]          n,
  input  logic [7:0]          vx,
  input  logic [7:0]          vy,
  sprite_fetch_if.master      mem,
  output logic [SPRITE_W-1:0] sprite_data,
  output logic [7:0]          height,
  output logic [7:0]          row,
  output logic [7:0]          col,
  output logic                draw,
  output logic                busy,
  output logic                done
);

  fetch_state_t state_q, state_d;

  logic [ADDR_W-1:0]   base_q, base_d;
  logic [3:0]          k_q, k_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [SPRITE_W-1:0] sprite_q, sprite_d;
  logic [7:0]          height_q, height_d;
  logic [7:0]          row_q, row_d;
  logic [7:0]          col_q, col_d;

  logic [7:0] start_row;
  logic [7:0] start_col;
  logic [3:0] fetch_rows;

  assign start_row = vy & 8'(SCREEN_H - 1);
  assign start_col = vx & 8'(SCREEN_W - 1);

`ifdef SPRITE_FETCH_CLIP_EN
  logic [8:0] room;
  // room is 1..SCREEN_H, so whenever it is below n it fits in four bits
  assign room       = 9'(SCREEN_H) - {1'b0, start_row};
  assign fetch_rows = ({5'd0, n} < room) ? n : room[3:0];
`else
  assign fetch_rows = n;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = (fetch_rows == 4'd0) ? ST_DONE : ST_FETCH;
      ST_FETCH: if (mem.mem_valid && (k_q + 4'd1 == cnt_q)) state_d = ST_DRAW;
      ST_DRAW:  state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem.mem_req  = (state_q == ST_FETCH);
    mem.mem_addr = base_q + {{(ADDR_W-4){1'b0}}, k_q};
    draw         = (state_q == ST_DRAW);
    done         = (state_q == ST_DONE);
    busy         = (state_q != ST_IDLE);
  end

  always_comb begin
    base_d   = base_q;
    k_d      = k_q;
    cnt_d    = cnt_q;
    sprite_d = sprite_q;
    height_d = height_q;
    row_d    = row_q;
    col_d    = col_q;
    if (state_q == ST_IDLE && start) begin
      base_d   = i_addr;
      k_d      = 4'd0;
      cnt_d    = fetch_rows;
      sprite_d = '0;
      height_d = {4'd0, fetch_rows};
      row_d    = start_row;
      col_d    = start_col;
    end else if (state_q == ST_FETCH && mem.mem_valid) begin
      sprite_d = place_row(sprite_q, k_q, mem.mem_rdata);
      k_d      = k_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base_q   <= '0;
      k_q      <= '0;
      cnt_q    <= '0;
      sprite_q <= '0;
      height_q <= '0;
      row_q    <= '0;
      col_q    <= '0;
    end else begin
      base_q   <= base_d;
      k_q      <= k_d;
      cnt_q    <= cnt_d;
      sprite_q <= sprite_d;
      height_q <= height_d;
      row_q    <= row_d;
      col_q    <= col_d;
    end
  end

  assign sprite_data = sprite_q;
  assign height      = height_q;
  assign row         = row_q;
  assign col         = col_q;

endmodule

// File: tb/tb_sprite_fetch.sv
// Scoreboard bench for sprite_fetch: directed commands push expected reads/draws/dones,
// a negedge monitor with an embedded memory responder pops and compares them.
module tb_sprite_fetch;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [11:0]  i_addr = '0;
  logic [3:0]   n = '0;
  logic [7:0]   vx = '0;
  logic [7:0]   vy = '0;
  logic [119:0] sprite_data;
  logic [7:0]   height, row, col;
  logic         draw, busy, done;

  sprite_fetch_if bus ();

  sprite_fetch dut (
    .clk(clk), .rst_n(rst_n), .start(start), .i_addr(i_addr), .n(n), .vx(vx), .vy(vy),
    .mem(bus), .sprite_data(sprite_data), .height(height), .row(row), .col(col),
    .draw(draw), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [119:0] data;
    logic [7:0]   h;
    logic [7:0]   r;
    logic [7:0]   c;
    int           cyc;
  } draw_exp_t;

  logic [11:0] addr_q[$];
  draw_exp_t   draw_q[$];
  int          done_q[$];

  logic [7:0] mem_arr [0:4095];
  int  cyc = 0;
  int  wait_cfg = 0;
  int  wcnt = 0;
  logic spurious = 1'b0;
  int  n_checks = 0;
  int  n_errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // memory responder followed by the monitor, both away from the active edge
  always @(negedge clk) begin
    if (bus.mem_req) begin
      if (wcnt >= wait_cfg) begin
        bus.mem_valid = 1'b1;
        bus.mem_rdata = mem_arr[bus.mem_addr];
        wcnt = 0;
      end else begin
        bus.mem_valid = 1'b0;
        bus.mem_rdata = 8'($urandom);
        wcnt++;
      end
    end else begin
      bus.mem_valid = spurious;
      bus.mem_rdata = 8'hEE;
      wcnt = 0;
    end

    if (rst_n) begin
      if (bus.mem_req) begin
        if (addr_q.size() == 0) chk("unexpected_mem_req", bus.mem_req, 1'b0);
        else begin
          chk("mem_addr", bus.mem_addr, addr_q[0]);
          if (bus.mem_valid) void'(addr_q.pop_front());
        end
      end
      if (draw) begin
        if (draw_q.size() == 0) chk("unexpected_draw", draw, 1'b0);
        else begin
          draw_exp_t e;
          e = draw_q.pop_front();
          chk("draw_cycle", cyc, e.cyc);
          chk("sprite_data", sprite_data, e.data);
          chk("height", height, e.h);
          chk("row", row, e.r);
          chk("col", col, e.c);
          chk("draw_mem_req", bus.mem_req, 1'b0);
        end
      end
      if (done) begin
        if (done_q.size() == 0) chk("unexpected_done", done, 1'b0);
        else begin
          int dc;
          dc = done_q.pop_front();
          chk("done_cycle", cyc, dc);
          chk("done_busy", busy, 1'b1);
        end
      end
    end
  end

  // issue one command; offsets are relative to the cycle start is presented in
  task automatic cmd(input logic [11:0] a, input logic [3:0] nn, input logic [7:0] x,
                     input logic [7:0] y, input int nreads, input logic [119:0] exp_data,
                     input logic [7:0] exp_h, input logic [7:0] exp_r, input logic [7:0] exp_c,
                     input int draw_off, input int done_off);
    int t;
    draw_exp_t e;
    @(posedge clk); #2;
    t = cyc;
    for (int k = 0; k < nreads; k++) addr_q.push_back(a + 12'(k));
    if (draw_off > 0) begin
      e.data = exp_data; e.h = exp_h; e.r = exp_r; e.c = exp_c; e.cyc = t + draw_off;
      draw_q.push_back(e);
    end
    done_q.push_back(t + done_off);
    i_addr = a; n = nn; vx = x; vy = y; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic drain();
    int b;
    b = 0;
    while ((addr_q.size() + draw_q.size() + done_q.size()) != 0 && b < 300) begin
      @(posedge clk); b++;
    end
    chk("queues_drained", addr_q.size() + draw_q.size() + done_q.size(), 0);
    repeat (3) @(posedge clk);
    #2;
  endtask

  initial begin
    bus.mem_valid = 1'b0;
    bus.mem_rdata = 8'h00;
    for (int i = 0; i < 4096; i++) mem_arr[i] = 8'h00;
    mem_arr[12'h050] = 8'hF0; mem_arr[12'h051] = 8'h90; mem_arr[12'h052] = 8'h90;
    mem_arr[12'h053] = 8'h90; mem_arr[12'h054] = 8'hF0;
    mem_arr[12'h100] = 8'h3C;
    mem_arr[12'hFFE] = 8'h11; mem_arr[12'hFFF] = 8'h22; mem_arr[12'h000] = 8'h33;
    mem_arr[12'h200] = 8'hAA; mem_arr[12'h201] = 8'h55;
    for (int i = 0; i < 8; i++) mem_arr[12'h300 + i] = 8'(i + 1);
    for (int i = 0; i < 4; i++) mem_arr[12'h400 + i] = 8'hC0 + 8'(i);

    repeat (3) @(posedge clk);
    #2;
    chk("rst_mem_req", bus.mem_req, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, 12'h000);
    chk("rst_sprite", sprite_data, 120'h0);
    chk("rst_hrc", {height, row, col}, 24'h0);
    chk("rst_flags", {draw, busy, done}, 3'b000);
    rst_n = 1'b1;

    // basic zero-wait fetch
    cmd(12'h050, 4'd5, 8'd0, 8'd0, 5, {40'hF0909090F0, 80'h0}, 8'd5, 8'd0, 8'd0, 6, 7);
    drain();
    // coordinate wrap
    cmd(12'h100, 4'd1, 8'd70, 8'd40, 1, {8'h3C, 112'h0}, 8'd1, 8'd8, 8'd6, 2, 3);
    drain();
    // address wrap past 0xFFF
    cmd(12'hFFE, 4'd3, 8'd1, 8'd2, 3, {24'h112233, 96'h0}, 8'd3, 8'd2, 8'd1, 4, 5);
    drain();
    // zero height: done only
    cmd(12'h123, 4'd0, 8'd4, 8'd4, 0, 120'h0, 8'd0, 8'd0, 8'd0, 0, 1);
    drain();

    // stray mem_valid while idle
    spurious = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    spurious = 1'b0;
    chk("idle_after_spurious", {bus.mem_req, busy}, 2'b00);

    // three wait cycles per byte, with a start pulse during FETCH that must be ignored
    wait_cfg = 3;
    cmd(12'h200, 4'd2, 8'd3, 8'd5, 2, {16'hAA55, 104'h0}, 8'd2, 8'd5, 8'd3, 9, 10);
    @(posedge clk); #2;
    @(posedge clk); #2;
    i_addr = 12'h7FF; n = 4'd1; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    drain();
    wait_cfg = 0;
    chk("hold_sprite", sprite_data, {16'hAA55, 104'h0});
    chk("hold_hrc", {height, row, col}, {8'd2, 8'd5, 8'd3});

    // bottom-edge sprite
`ifdef SPRITE_FETCH_CLIP_EN
    cmd(12'h300, 4'd8, 8'd10, 8'd28, 4, {32'h01020304, 88'h0}, 8'd4, 8'd28, 8'd10, 5, 6);
`else
    cmd(12'h300, 4'd8, 8'd10, 8'd28, 8, {64'h0102030405060708, 56'h0}, 8'd8, 8'd28, 8'd10, 9, 10);
`endif
    drain();

    // reset in the middle of a fetch
    wait_cfg = 2;
    @(posedge clk); #2;
    for (int k = 0; k < 4; k++) addr_q.push_back(12'h400 + 12'(k));
    i_addr = 12'h400; n = 4'd4; vx = 8'd9; vy = 8'd7; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("pre_rst_busy", busy, 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #2;
    addr_q.delete();
    chk("abort_mem_req", bus.mem_req, 1'b0);
    chk("abort_mem_addr", bus.mem_addr, 12'h000);
    chk("abort_sprite", sprite_data, 120'h0);
    chk("abort_hrc", {height, row, col}, 24'h0);
    chk("abort_flags", {draw, busy, done}, 3'b000);
    @(posedge clk); #2;
    rst_n = 1'b1;
    wait_cfg = 0;
    repeat (20) @(posedge clk);
    #2;
    chk("post_abort_idle", {bus.mem_req, busy}, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
